// File: rtl/sniffer_pkg.sv
// Shared definitions for the sniffer capture path.
//   - wr_state_e     : FX2 packet writer states (IDLE, STREAM, FLUSH, HOLD)
//   - DEF_*          : default packet geometry and timeout values
package sniffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_HOLD   = 2'd3
    } wr_state_e;

    // 256 words = 512-byte high-speed bulk packet
    localparam int DEF_PKT_WORDS    = 256;
    localparam int DEF_IDLE_TIMEOUT = 4096;
    localparam int DEF_HOLDOFF      = 3;

endpackage

// File: rtl/fx2_idle_timer.sv
// Saturating idle counter with clear, hold and a done flag.
// Ports:
//   clk_i     in   clock
//   reset_i   in   synchronous active-high reset
//   clear_i   in   force count to zero (priority over enable)
//   enable_i  in   count one step when not saturated; hold otherwise
//   done_o    out  count has reached LIMIT
module fx2_idle_timer
#(
    parameter int LIMIT = 4096
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic done_o
);

    localparam int TW = $clog2(LIMIT + 1);
    localparam logic [TW-1:0] LIMIT_C = TW'(LIMIT);

    logic [TW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, then saturating increment, else hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {TW{1'b0}};
        end else if (enable_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + TW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= {TW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/fx2_pkt_writer.sv
// Drains 16-bit words from the clock-crossing FIFO read side into the FX2
// slave FIFO, tracking the word position inside each bulk packet and closing
// short packets with PKTEND after an idle timeout or on a flush request.
// Ports:
//   clk_i       in   interface clock (ifclk)
//   reset_i     in   synchronous active-high reset
//   rd_data_i   in   FIFO head word
//   rd_valid_i  in   FIFO head valid
//   rd_en_o     out  FIFO pop (same as slwr_o)
//   flagb_i     in   FX2 FIFO full
//   flush_i     in   one-cycle flush request
//   slwr_o      out  FX2 write strobe (combinational)
//   pktend_o    out  FX2 packet end (registered, one cycle)
//   fd_o        out  FX2 data bus (pass-through of rd_data_i)
//   words_o     out  word position in the current packet
//   busy_o      out  writer not idle
module fx2_pkt_writer
    import sniffer_pkg::*;
#(
    parameter int PKT_WORDS    = DEF_PKT_WORDS,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
    parameter int HOLDOFF      = DEF_HOLDOFF
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [15:0]                  rd_data_i,
    input  logic                         rd_valid_i,
    output logic                         rd_en_o,
    input  logic                         flagb_i,
    input  logic                         flush_i,
    output logic                         slwr_o,
    output logic                         pktend_o,
    output logic [15:0]                  fd_o,
    output logic [$clog2(PKT_WORDS)-1:0] words_o,
    output logic                         busy_o
);

    localparam int WW = $clog2(PKT_WORDS);
    // Hold counter runs 0..HOLDOFF-1; the PKTEND cycle is the first of them.
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

    wr_state_e     state_q, state_d;
    logic [WW-1:0] words_q, words_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          flush_pending_q, flush_pending_d;
    logic          pktend_q, pktend_d;

    logic slwr_s;
    logic pkt_issue_s;
    logic timer_clear_s;
    logic timer_en_s;
    logic timer_done_s;

    // flush_i gates the strobe directly so a coincident word stays in the FIFO.
    assign slwr_s = rd_valid_i && !flagb_i && (state_q == ST_STREAM) &&
                    !flush_pending_q && !flush_i && !reset_i;
    assign pkt_issue_s = (state_q == ST_FLUSH) && !flagb_i;

    // Timer only runs with a partial packet outstanding and freezes in FLUSH.
    assign timer_clear_s = slwr_s || pkt_issue_s || (words_q == {WW{1'b0}});
    assign timer_en_s    = (state_q != ST_FLUSH);

    fx2_idle_timer #(
        .LIMIT    (IDLE_TIMEOUT)
    ) u_idle_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (timer_clear_s),
        .enable_i (timer_en_s),
        .done_o   (timer_done_s)
    );

    // State transitions, PKTEND request and holdoff count.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        pktend_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_pending_q || timer_done_s) begin
                    state_d = ST_FLUSH;
                end else if (rd_valid_i) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (timer_done_s || flush_pending_q) begin
                    state_d = ST_FLUSH;
                end else if (!rd_valid_i && (words_q == {WW{1'b0}})) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                if (!flagb_i) begin
                    pktend_d = 1'b1;
                    hold_d   = {HW{1'b0}};
                    state_d  = ST_HOLD;
                end else begin
                    state_d  = ST_FLUSH;
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = rd_valid_i ? ST_STREAM : ST_IDLE;
                end else begin
                    hold_d  = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Word position and flush latch; a flush arriving in FLUSH/HOLD is absorbed.
    always_comb begin
        words_d         = words_q;
        flush_pending_d = flush_pending_q;
        if (pkt_issue_s) begin
            words_d         = {WW{1'b0}};
            flush_pending_d = 1'b0;
        end else begin
            if (slwr_s) begin
                words_d = words_q + WW'(1);
            end else begin
                words_d = words_q;
            end
            if (flush_i && ((state_q == ST_IDLE) || (state_q == ST_STREAM))) begin
                flush_pending_d = 1'b1;
            end else begin
                flush_pending_d = flush_pending_q;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            words_q         <= {WW{1'b0}};
            hold_q          <= {HW{1'b0}};
            flush_pending_q <= 1'b0;
            pktend_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            words_q         <= words_d;
            hold_q          <= hold_d;
            flush_pending_q <= flush_pending_d;
            pktend_q        <= pktend_d;
        end
    end

    assign fd_o     = rd_data_i;
    assign slwr_o   = slwr_s;
    assign rd_en_o  = slwr_s;
    assign pktend_o = pktend_q;
    assign words_o  = words_q;
    assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fx2_pkt_writer.sv
// Self-checking bench for fx2_pkt_writer (PKT_WORDS=256, IDLE_TIMEOUT=16,
// HOLDOFF=3). The bench owns a FIFO model (queue) that feeds the writer and
// records every word accepted on the FX2 side; per-cycle checks compare the
// strobe, data and packet position against rules computed from the queue.
module tb_fx2_pkt_writer;

    localparam int PKT = 256;
    localparam int TO  = 16;
    localparam int HO  = 3;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [15:0] rd_data_i;
    logic        rd_valid_i;
    logic        rd_en_o;
    logic        flagb_i;
    logic        flush_i;
    logic        slwr_o;
    logic        pktend_o;
    logic [15:0] fd_o;
    logic [7:0]  words_o;
    logic        busy_o;

    fx2_pkt_writer #(
        .PKT_WORDS    (PKT),
        .IDLE_TIMEOUT (TO),
        .HOLDOFF      (HO)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .rd_data_i  (rd_data_i),
        .rd_valid_i (rd_valid_i),
        .rd_en_o    (rd_en_o),
        .flagb_i    (flagb_i),
        .flush_i    (flush_i),
        .slwr_o     (slwr_o),
        .pktend_o   (pktend_o),
        .fd_o       (fd_o),
        .words_o    (words_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [15:0] src[$];      // FIFO contents still to be written
    logic [15:0] sent[$];     // words seen on fd_o with slwr_o
    logic [15:0] exp_all[$];  // every word ever pushed, in order

    logic valid_en;
    int   model_words;        // writes since last PKTEND/reset, mod PKT
    int   n_slwr, n_pktend, cyc_n, last_slwr_cyc, last_pktend_cyc;
    logic s_slwr, s_pktend, s_busy, s_rden;
    logic [7:0] s_words;

    task automatic push_words(input int n);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            src.push_back(w);
            exp_all.push_back(w);
        end
    endtask

    // One clock cycle: present FIFO head, sample mid-cycle, run monitors, clock.
    task automatic cyc();
        logic [7:0] exp_w;
        rd_valid_i = valid_en && (src.size() != 0);
        rd_data_i  = (src.size() != 0) ? src[0] : 16'($urandom);
        #4;
        s_slwr = slwr_o; s_pktend = pktend_o; s_busy = busy_o;
        s_rden = rd_en_o; s_words = words_o;
        checks++;
        if (s_rden !== s_slwr) begin
            errors++; $display("FAIL rd_en_eq_slwr: rd_en=%b slwr=%b", s_rden, s_slwr);
        end
        checks++;
        if (s_slwr === 1'b1 && s_pktend === 1'b1) begin
            errors++; $display("FAIL slwr_pktend_excl: slwr=1 pktend=1 at cycle %0d", cyc_n);
        end
        if (s_slwr === 1'b1) begin
            checks++;
            if (!rd_valid_i || flagb_i || flush_i || reset_i) begin
                errors++;
                $display("FAIL slwr_gating: slwr=1 with valid=%b flagb=%b flush=%b reset=%b",
                         rd_valid_i, flagb_i, flush_i, reset_i);
            end
            if (src.size() != 0) begin
                checks++;
                if (fd_o !== src[0]) begin
                    errors++; $display("FAIL fd_data: got %h want %h", fd_o, src[0]);
                end
                sent.push_back(fd_o);
                void'(src.pop_front());
            end
            n_slwr++;
            last_slwr_cyc = cyc_n;
        end
        exp_w = (s_pktend === 1'b1) ? 8'd0 : 8'(model_words);
        checks++;
        if (s_words !== exp_w) begin
            errors++; $display("FAIL words_pos: got %0d want %0d at cycle %0d", s_words, exp_w, cyc_n);
        end
        if (s_pktend === 1'b1) begin
            n_pktend++;
            last_pktend_cyc = cyc_n;
            model_words = 0;
        end
        @(posedge clk_i);
        #1;
        if (reset_i) model_words = 0;
        else if (s_slwr === 1'b1) model_words = (model_words + 1) % PKT;
        cyc_n++;
    endtask

    // Feed everything and wait for the writer to go idle again.
    task automatic drain(input string name);
        bit done = 1'b0;
        valid_en = 1'b1; flagb_i = 1'b0; flush_i = 1'b0;
        for (int i = 0; i < 600; i++) begin
            cyc();
            if (src.size() == 0 && s_busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL %s_drain: left=%0d busy=%b", name, src.size(), s_busy);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({s_slwr, s_pktend, s_rden, s_busy} !== 4'b0000 || s_words !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: slwr=%b pktend=%b rden=%b busy=%b words=%0d want all 0",
                     s_slwr, s_pktend, s_rden, s_busy, s_words);
        end
        reset_i = 1'b0;
        cyc();
        checks++;
        if (s_busy !== 1'b0 || s_pktend !== 1'b0) begin
            errors++; $display("FAIL reset_release: busy=%b pktend=%b want 0 0", s_busy, s_pktend);
        end
    endtask

    task automatic test_full_packet();
        int w0 = n_slwr, p0 = n_pktend;
        push_words(PKT);
        drain("full");
        repeat (30) cyc();
        checks++;
        if (n_slwr - w0 != PKT) begin
            errors++; $display("FAIL full_writes: got %0d want %0d", n_slwr - w0, PKT);
        end
        checks++;
        if (n_pktend != p0) begin
            errors++; $display("FAIL full_no_pktend: got %0d want 0", n_pktend - p0);
        end
        checks++;
        if (s_words !== 8'd0) begin
            errors++; $display("FAIL full_wrap: words=%0d want 0", s_words);
        end
    endtask

    task automatic test_timeout();
        int w0 = n_slwr, p0 = n_pktend, lat;
        push_words(10);
        drain("timeout");
        checks++;
        if (n_slwr - w0 != 10 || n_pktend - p0 != 1) begin
            errors++;
            $display("FAIL timeout_counts: writes=%0d pktends=%0d want 10 1", n_slwr - w0, n_pktend - p0);
        end
        // Timer must see IDLE_TIMEOUT idle cycles, then FSM + registered PKTEND.
        lat = last_pktend_cyc - last_slwr_cyc;
        checks++;
        if (lat < TO || lat > TO + 3) begin
            errors++; $display("FAIL timeout_latency: got %0d want %0d..%0d", lat, TO, TO + 3);
        end
    endtask

    task automatic test_zlp();
        int w0 = n_slwr, p0 = n_pktend;
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        repeat (20) cyc();
        checks++;
        if (n_pktend - p0 != 1 || n_slwr != w0) begin
            errors++;
            $display("FAIL zlp: pktends=%0d writes=%0d want 1 0", n_pktend - p0, n_slwr - w0);
        end
        checks++;
        if (s_busy !== 1'b0) begin
            errors++; $display("FAIL zlp_idle: busy=%b want 0", s_busy);
        end
    endtask

    task automatic test_flagb();
        int w0 = n_slwr;
        push_words(60);
        valid_en = 1'b1; flagb_i = 1'b1;
        repeat (50) cyc();
        checks++;
        if (n_slwr != w0) begin
            errors++; $display("FAIL flagb_block: writes=%0d want 0", n_slwr - w0);
        end
        flagb_i = 1'b0;
        cyc();
        checks++;
        if (s_slwr !== 1'b1) begin
            errors++; $display("FAIL flagb_resume: slwr=%b want 1", s_slwr);
        end
        drain("flagb");
        checks++;
        if (n_slwr - w0 != 60) begin
            errors++; $display("FAIL flagb_count: got %0d want 60", n_slwr - w0);
        end
    endtask

    task automatic test_flush_coincident();
        int w0 = n_slwr, p0 = n_pktend, pk;
        bit seen = 1'b0;
        push_words(10);
        valid_en = 1'b1;
        for (int i = 0; i < 20 && (n_slwr - w0) < 4; i++) cyc();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        checks++;
        if (s_slwr !== 1'b0 || n_slwr - w0 != 4) begin
            errors++;
            $display("FAIL flush_suppress: slwr=%b writes=%0d want 0 4", s_slwr, n_slwr - w0);
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (s_pktend === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || n_slwr - w0 != 4) begin
            errors++; $display("FAIL flush_pktend: seen=%b writes=%0d want 1 4", seen, n_slwr - w0);
        end
        pk = cyc_n - 1;
        repeat (HO - 1) begin
            cyc();
            checks++;
            if (s_slwr !== 1'b0) begin
                errors++; $display("FAIL flush_holdoff: slwr=%b want 0", s_slwr);
            end
        end
        cyc();
        checks++;
        if (s_slwr !== 1'b1 || last_slwr_cyc - pk != HO) begin
            errors++;
            $display("FAIL flush_resume: slwr=%b gap=%0d want 1 %0d", s_slwr, last_slwr_cyc - pk, HO);
        end
        drain("flush");
        checks++;
        if (n_pktend - p0 != 2) begin
            errors++; $display("FAIL flush_pktends: got %0d want 2", n_pktend - p0);
        end
    endtask

    task automatic test_reset_mid();
        int w0 = n_slwr, p0 = n_pktend;
        push_words(20);
        valid_en = 1'b1;
        for (int i = 0; i < 20 && (n_slwr - w0) < 7; i++) cyc();
        reset_i = 1'b1;
        cyc();
        checks++;
        if (s_slwr !== 1'b0 || s_rden !== 1'b0) begin
            errors++; $display("FAIL reset_no_pop: slwr=%b rden=%b want 0 0", s_slwr, s_rden);
        end
        reset_i = 1'b0;
        cyc();
        checks++;
        if ({s_slwr, s_pktend, s_rden, s_busy} !== 4'b0000 || s_words !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: slwr=%b pktend=%b rden=%b busy=%b words=%0d want all 0",
                     s_slwr, s_pktend, s_rden, s_busy, s_words);
        end
        checks++;
        if (n_pktend != p0 || n_slwr - w0 != 7) begin
            errors++;
            $display("FAIL reset_mid_abandon: pktends=%0d writes=%0d want 0 7", n_pktend - p0, n_slwr - w0);
        end
        drain("reset_mid");
    endtask

    task automatic test_random();
        push_words(120);
        for (int i = 0; i < 300; i++) begin
            valid_en = ($urandom_range(0, 3) != 0);
            flagb_i  = ($urandom_range(0, 4) == 0);
            flush_i  = ($urandom_range(0, 29) == 0);
            cyc();
        end
        drain("random");
    endtask

    task automatic test_order();
        checks++;
        if (sent.size() != exp_all.size()) begin
            errors++; $display("FAIL order_size: got %0d want %0d", sent.size(), exp_all.size());
        end else begin
            for (int i = 0; i < sent.size(); i++) begin
                checks++;
                if (sent[i] !== exp_all[i]) begin
                    errors++; $display("FAIL order_word: idx %0d got %h want %h", i, sent[i], exp_all[i]);
                end
            end
        end
    endtask

    initial begin
        reset_i = 1'b1; flagb_i = 1'b0; flush_i = 1'b0; valid_en = 1'b0;
        rd_valid_i = 1'b0; rd_data_i = 16'd0;
        model_words = 0; n_slwr = 0; n_pktend = 0; cyc_n = 0;
        last_slwr_cyc = 0; last_pktend_cyc = 0;
        @(posedge clk_i);
        #1;
        test_reset();
        test_full_packet();
        test_timeout();
        test_zlp();
        test_flagb();
        test_flush_coincident();
        test_reset_mid();
        test_random();
        test_order();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
